// File: rtl/wb_store_buffer.sv
// Posted-store buffer between writeback and the dcache write port: in-order FIFO drain,
// granule-level load conflict detection and a drain/empty handshake for serialising ops.
module wb_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WB_st_valid,
  input  logic [31:0]       WB_st_address,
  input  logic [63:0]       WB_st_data,
  input  logic [1:0]        WB_st_size,
  output logic              WB_st_accept,
  output logic              DC_wr_req,
  output logic [31:0]       DC_wr_address,
  output logic [63:0]       DC_wr_data,
  output logic [1:0]        DC_wr_size,
  input  logic              DC_wr_ready,
  input  logic              MEM_ld_check,
  input  logic [31:0]       MEM_ld_address,
  output logic              MEM_ld_conflict,
  input  logic              SB_drain,
  output logic              SB_empty,
  output logic [CNT_W-1:0]  SB_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_valid;
  logic [31:0]      r_addr [DEPTH];
  logic [63:0]      r_data [DEPTH];
  logic [1:0]       r_size [DEPTH];

  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_match;
  logic             w_push_match;

  // Acceptance uses start-of-cycle occupancy only; a same-cycle pop never frees a slot early.
  assign WB_st_accept  = (r_count < DEPTH_CNT) & ~SB_drain & (r_state != StDrain);
  assign w_push        = WB_st_valid & WB_st_accept;
  assign DC_wr_req     = r_valid[r_head];
  assign w_pop         = DC_wr_req & DC_wr_ready;
  assign DC_wr_address = r_addr[r_head];
  assign DC_wr_data    = r_data[r_head];
  assign DC_wr_size    = r_size[r_head];
  assign SB_empty      = (r_count == '0);
  assign SB_count      = r_count;

  // Overlap is judged at 8-byte granule regardless of access size.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign w_match[g] = r_valid[g] & (r_addr[g][31:3] == MEM_ld_address[31:3]);
  end
  assign w_push_match    = w_push & (WB_st_address[31:3] == MEM_ld_address[31:3]);
  assign MEM_ld_conflict = MEM_ld_check & ((|w_match) | w_push_match);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_addr  <= '{default: '0};
      r_data  <= '{default: '0};
      r_size  <= '{default: '0};
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= WB_st_address;
        r_data[r_tail]  <= WB_st_data;
        r_size[r_tail]  <= WB_st_size;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_push) w_state_d = StActive;
      end
      StActive: begin
        // Last entry leaving takes priority so a drain request never strands DRAIN at count 0.
        if (w_pop && !w_push && (r_count == ONE_CNT)) begin
          w_state_d = StIdle;
        end else if (SB_drain) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && (r_count == ONE_CNT)) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_wb_store_buffer.sv
// Scenario-driven bench for wb_store_buffer; a scoreboard queue tracks the expected dcache
// write sequence and is checked whenever the buffer hands a store to the cache.
module tb_wb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  s;
  } ent_t;

  logic             CLK = 1'b0;
  logic             CLR;
  logic             WB_st_valid;
  logic [31:0]      WB_st_address;
  logic [63:0]      WB_st_data;
  logic [1:0]       WB_st_size;
  logic             WB_st_accept;
  logic             DC_wr_req;
  logic [31:0]      DC_wr_address;
  logic [63:0]      DC_wr_data;
  logic [1:0]       DC_wr_size;
  logic             DC_wr_ready;
  logic             MEM_ld_check;
  logic [31:0]      MEM_ld_address;
  logic             MEM_ld_conflict;
  logic             SB_drain;
  logic             SB_empty;
  logic [CNT_W-1:0] SB_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t sb[$];

  wb_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK             (CLK),
    .CLR             (CLR),
    .WB_st_valid     (WB_st_valid),
    .WB_st_address   (WB_st_address),
    .WB_st_data      (WB_st_data),
    .WB_st_size      (WB_st_size),
    .WB_st_accept    (WB_st_accept),
    .DC_wr_req       (DC_wr_req),
    .DC_wr_address   (DC_wr_address),
    .DC_wr_data      (DC_wr_data),
    .DC_wr_size      (DC_wr_size),
    .DC_wr_ready     (DC_wr_ready),
    .MEM_ld_check    (MEM_ld_check),
    .MEM_ld_address  (MEM_ld_address),
    .MEM_ld_conflict (MEM_ld_conflict),
    .SB_drain        (SB_drain),
    .SB_empty        (SB_empty),
    .SB_count        (SB_count)
  );

  always #5 CLK = ~CLK;

  // Every handshake that will complete at the next rising edge must match the scoreboard head.
  always @(negedge CLK) begin
    if (CLR && DC_wr_req && DC_wr_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_order: unexpected write addr=%h data=%h size=%0d, none expected",
                 DC_wr_address, DC_wr_data, DC_wr_size);
      end else begin
        ent_t e;
        e = sb.pop_front();
        if ({DC_wr_address, DC_wr_data, DC_wr_size} !== e) begin
          n_fail++;
          $display("FAIL sb_order: got addr=%h data=%h size=%0d, want addr=%h data=%h size=%0d",
                   DC_wr_address, DC_wr_data, DC_wr_size, e.a, e.d, e.s);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    WB_st_valid   = 1'b1;
    WB_st_address = a;
    WB_st_data    = d;
    WB_st_size    = s;
  endtask

  task automatic sb_push(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    ent_t e;
    e.a = a;
    e.d = d;
    e.s = s;
    sb.push_back(e);
  endtask

  // Returns aligned just after a rising edge; ok is cleared if the buffer never emptied.
  task automatic run_until_empty(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (SB_empty) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
    next_cycle();
  endtask

  task automatic test_reset();
    CLR = 1'b0; WB_st_valid = 1'b0; WB_st_address = '0; WB_st_data = '0; WB_st_size = '0;
    DC_wr_ready = 1'b0; MEM_ld_check = 1'b1; MEM_ld_address = '0; SB_drain = 1'b0;
    #3;
    n_checks++;
    if ({DC_wr_req, SB_count, SB_empty, MEM_ld_conflict, WB_st_accept} !== {1'b0, 3'd0, 3'b101}) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b cnt=%0d empty=%b conf=%b acc=%b, want 0 0 1 0 1",
               DC_wr_req, SB_count, SB_empty, MEM_ld_conflict, WB_st_accept);
    end
    n_checks++;
    if ({DC_wr_address, DC_wr_data, DC_wr_size} !== 98'd0) begin
      n_fail++;
      $display("FAIL reset_fields: addr=%h data=%h size=%0d, want all zero",
               DC_wr_address, DC_wr_data, DC_wr_size);
    end
    SB_drain = 1'b1;
    #1;
    n_checks++;
    if (WB_st_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drain_accept: accept=%b, want 0", WB_st_accept);
    end
    SB_drain = 1'b0; MEM_ld_check = 1'b0;
    @(posedge CLK);
    #2 CLR = 1'b1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h0000_0100 + 32'(i * 8), 64'(i + 7), 2'b01);
      next_cycle();
    end
    WB_st_valid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({DC_wr_req, SB_count} !== {1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL reset_prefill: req=%b cnt=%0d, want 1 3", DC_wr_req, SB_count);
    end
    #1 CLR = 1'b0;
    #1;
    n_checks++;
    if ({DC_wr_req, SB_count, SB_empty} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_midstream: req=%b cnt=%0d empty=%b, want 0 0 1",
               DC_wr_req, SB_count, SB_empty);
    end
    sb.delete();
    @(posedge CLK);
    #2 CLR = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({WB_st_accept, SB_count} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_release: accept=%b cnt=%0d, want 1 0", WB_st_accept, SB_count);
    end
    next_cycle();
  endtask

  task automatic test_single_store();
    DC_wr_ready = 1'b1;
    drive_store(32'h0000_1000, 64'h0000_0000_0000_AABB, 2'b10);
    sb_push(32'h0000_1000, 64'h0000_0000_0000_AABB, 2'b10);
    @(negedge CLK);
    n_checks++;
    if ({WB_st_accept, DC_wr_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_push: accept=%b req=%b, want 1 0 (no bypass)", WB_st_accept, DC_wr_req);
    end
    next_cycle();
    WB_st_valid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({DC_wr_req, DC_wr_address, DC_wr_data, DC_wr_size} !==
        {1'b1, 32'h0000_1000, 64'h0000_0000_0000_AABB, 2'b10}) begin
      n_fail++;
      $display("FAIL single_present: req=%b addr=%h data=%h size=%0d, want 1 1000 aabb 2",
               DC_wr_req, DC_wr_address, DC_wr_data, DC_wr_size);
    end
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if ({SB_empty, DC_wr_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_empty: empty=%b req=%b, want 1 0", SB_empty, DC_wr_req);
    end
    next_cycle();
  endtask

  task automatic test_fill();
    bit ok;
    DC_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_store(32'h0000_4000 + 32'(i * 8), 64'h1111_0000_0000_0000 + 64'(i + 1), 2'b10);
      @(negedge CLK);
      n_checks++;
      if (WB_st_accept !== (i < 4)) begin
        n_fail++;
        $display("FAIL fill_accept[%0d]: accept=%b, want %b", i, WB_st_accept, (i < 4));
      end
      if (i < 4) sb_push(WB_st_address, WB_st_data, WB_st_size);
      if (i < 4) next_cycle();
    end
    next_cycle();
    DC_wr_ready = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({WB_st_accept, SB_count} !== {1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL fill_full_ready: accept=%b cnt=%0d, want 0 4", WB_st_accept, SB_count);
    end
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if ({WB_st_accept, SB_count} !== {1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL fill_after_pop: accept=%b cnt=%0d, want 1 3", WB_st_accept, SB_count);
    end
    sb_push(WB_st_address, WB_st_data, WB_st_size);
    next_cycle();
    WB_st_valid = 1'b0;
    run_until_empty(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fill_drain_timeout: empty=%b, want 1", SB_empty);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    DC_wr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_store(32'h0000_6000 + 32'(i * 8), 64'hBEEF_0000 + 64'(i), 2'(i));
      sb_push(WB_st_address, WB_st_data, WB_st_size);
      next_cycle();
    end
    DC_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_store(32'h0000_7000 + 32'(i * 8), 64'hCAFE_0000 + 64'(i * 3), 2'(i + 1));
      @(negedge CLK);
      n_checks++;
      if ({WB_st_accept, SB_count} !== {1'b1, 3'd2}) begin
        n_fail++;
        $display("FAIL b2b_steady[%0d]: accept=%b cnt=%0d, want 1 2", i, WB_st_accept, SB_count);
      end
      sb_push(WB_st_address, WB_st_data, WB_st_size);
      next_cycle();
    end
    WB_st_valid = 1'b0;
    run_until_empty(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_drain_timeout: empty=%b, want 1", SB_empty);
    end
  endtask

  task automatic test_conflict();
    bit ok;
    DC_wr_ready = 1'b0;
    drive_store(32'h0000_2004, 64'h55, 2'b01);
    sb_push(32'h0000_2004, 64'h55, 2'b01);
    next_cycle();
    WB_st_valid = 1'b0;
    MEM_ld_check = 1'b1;
    MEM_ld_address = 32'h0000_2000;
    @(negedge CLK);
    n_checks++;
    if (MEM_ld_conflict !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_same_granule: conflict=%b, want 1", MEM_ld_conflict);
    end
    next_cycle();
    MEM_ld_address = 32'h0000_2008;
    @(negedge CLK);
    n_checks++;
    if (MEM_ld_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_next_granule: conflict=%b, want 0", MEM_ld_conflict);
    end
    next_cycle();
    MEM_ld_check = 1'b0;
    MEM_ld_address = 32'h0000_2000;
    @(negedge CLK);
    n_checks++;
    if (MEM_ld_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_no_check: conflict=%b, want 0", MEM_ld_conflict);
    end
    next_cycle();
    MEM_ld_check = 1'b1;
    MEM_ld_address = 32'h0000_3001;
    drive_store(32'h0000_3006, 64'h66, 2'b00);
    sb_push(32'h0000_3006, 64'h66, 2'b00);
    @(negedge CLK);
    n_checks++;
    if (MEM_ld_conflict !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_incoming: conflict=%b, want 1", MEM_ld_conflict);
    end
    next_cycle();
    WB_st_valid = 1'b0;
    MEM_ld_check = 1'b0;
    DC_wr_ready = 1'b1;
    run_until_empty(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL conflict_drain_timeout: empty=%b, want 1", SB_empty);
    end
  endtask

  task automatic test_drain();
    bit ok;
    bit reopened;
    DC_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h0000_8000 + 32'(i * 8), 64'hD0 + 64'(i), 2'b11);
      sb_push(WB_st_address, WB_st_data, WB_st_size);
      next_cycle();
    end
    drive_store(32'h0000_5000, 64'h5A5A, 2'b10);
    SB_drain = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (WB_st_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_same_cycle: accept=%b, want 0", WB_st_accept);
    end
    next_cycle();
    SB_drain = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (WB_st_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_held: accept=%b, want 0 after drain pulse", WB_st_accept);
    end
    next_cycle();
    DC_wr_ready = 1'b1;
    reopened = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      n_checks++;
      if (SB_empty) begin
        if (WB_st_accept !== 1'b1) begin
          n_fail++;
          $display("FAIL drain_reopen: accept=%b, want 1 once empty", WB_st_accept);
        end
        sb_push(32'h0000_5000, 64'h5A5A, 2'b10);
        reopened = 1'b1;
        break;
      end
      if (WB_st_accept !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_blocked[%0d]: accept=%b cnt=%0d, want 0", c, WB_st_accept, SB_count);
      end
      next_cycle();
    end
    n_checks++;
    if (!reopened) begin
      n_fail++;
      $display("FAIL drain_timeout: empty=%b, want 1", SB_empty);
    end
    next_cycle();
    WB_st_valid = 1'b0;
    run_until_empty(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_final_timeout: empty=%b, want 1", SB_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_fill();
    test_back_to_back();
    test_conflict();
    test_drain();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected writes never seen, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_store_buffer.md
# wb_store_buffer

Posted-store buffer between the writeback stage and the data cache write port. It absorbs validated writeback stores (GPR or MM data) into a DEPTH-entry FIFO and drains them in order through a req/ready handshake. Writeback stalls only when the buffer is full, not on every cache busy cycle. It also flags younger loads in the memory stage that overlap a pending store, and provides a drain/empty handshake for halt and serialising micro-ops.

## Interface
Parameters:
- DEPTH, 4, entry count; power of two, 2..8
- CNT_W, 3, width of SB_count; must hold DEPTH

Ports:
- CLK  in  1  clock; all state updates on rising edge
- CLR  in  1  asynchronous, active-low reset
- WB_st_valid  in  1  validated dcache store from writeback this cycle
- WB_st_address  in  32  store byte address
- WB_st_data  in  64  store data; upper 32 bits zero for non-MM stores
- WB_st_size  in  2  00 byte, 01 word, 10 dword, 11 qword
- WB_st_accept  out  1  buffer takes the store at this edge; writeback stalls when valid & !accept
- DC_wr_req  out  1  head entry presented to dcache
- DC_wr_address  out  32  head address
- DC_wr_data  out  64  head data
- DC_wr_size  out  2  head size
- DC_wr_ready  in  1  dcache accepts head when DC_wr_req & DC_wr_ready
- MEM_ld_check  in  1  memory stage has a valid load this cycle
- MEM_ld_address  in  32  load byte address
- MEM_ld_conflict  out  1  load overlaps a pending store; memory stage must stall
- SB_drain  in  1  block new stores and empty the buffer
- SB_empty  out  1  no entries pending
- SB_count  out  CNT_W  number of valid entries

## Operation
- Storage: circular FIFO with head pointer, tail pointer, count, and a per-entry valid bit. Pointers wrap modulo DEPTH.
- Push: occurs when WB_st_valid & WB_st_accept. The entry is written at the tail, and tail and count increment.
- WB_st_accept = (count < DEPTH) & !SB_drain & (state != DRAIN).
  - Decided from start-of-cycle count only. No accept-on-pop when full.
- Pop: occurs when DC_wr_req & DC_wr_ready. The head valid bit clears, and head increments.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- DC_wr_* comes combinationally from the head entry registers. DC_wr_req = head valid.
- No write-through bypass. An incoming store is never presented in its arrival cycle.
- Stores drain strictly in arrival order. There is no coalescing or reordering.
- Conflict check:
  - MEM_ld_conflict = MEM_ld_check & (any valid entry with address[31:3] == MEM_ld_address[31:3], or an accepted push this cycle whose address[31:3] matches).
  - Comparison is at 8-byte granule, independent of size. This is a conservative overlap test.
- FSM:
  - IDLE: count == 0.
    - Push goes to ACTIVE.
    - SB_drain keeps the FSM in IDLE with SB_empty = 1.
  - ACTIVE: count > 0.
    - SB_drain goes to DRAIN.
    - If the last entry pops with no push, go to IDLE.
  - DRAIN: no pushes.
    - Leave when count reaches 0 via a pop: go to IDLE.
    - SB_drain deassertion before then does not exit DRAIN.
- SB_empty = (count == 0). It is combinational from registered count.

## Timing
- Reset (CLR low, asynchronous):
  - count, head, tail, valid bits = 0, and state = IDLE.
  - Entry registers = 0, so DC_wr_address/data/size = 0.
  - DC_wr_req = 0, SB_empty = 1, SB_count = 0, MEM_ld_conflict = 0.
  - WB_st_accept = 1 unless SB_drain.
- Reset mid-operation discards all pending stores. No dcache write completes after CLR falls.
- Latency: a store pushed at edge N gives DC_wr_req = 1 in cycle N+1. With DC_wr_ready held high, the entry pops at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- Full buffer with DC_wr_ready = 1: accept is 0 that cycle, and 1 in the next cycle.
- DC_wr_req, once asserted, stays asserted with stable address/data/size until ready is seen.
- A DRAIN request issued at edge N blocks accepts in the same cycle as SB_drain is sampled high.

## Test plan
- Reset: drive CLR low mid-stream with 3 entries pending → DC_wr_req = 0 and SB_count = 0 immediately. After release, accept = 1.
- Single store: push addr 0x1000, data 0xAABB, size 10, ready = 1 → DC_wr_req high exactly one cycle later with the same fields. SB_empty = 1 after the pop.
- Fill: DC_wr_ready = 0, push 5 stores with DEPTH = 4 → 4 accepted, 5th sees accept = 0. Raise ready → drains in order 1..4. Store 5 is accepted the cycle after the first pop.
- Simultaneous push/pop at count 2 across the pointer wrap → count stays 2 and order is preserved through 10 back-to-back stores.
- Conflict: pending store at 0x2004 → load 0x2000 gives conflict = 1, load 0x2008 gives 0. Store arriving the same cycle as load 0x3001 with address 0x3006 → conflict = 1.
- Drain: 3 pending, pulse SB_drain one cycle with WB_st_valid held → no further accepts until SB_empty = 1, then accept returns to 1.
